wb_stage: RTL and testbench

//  Writeback stage of the 3-stage RV32I pipeline; sits directly upstream of the register file.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/load_aligner.sv | 56 +++++
 rtl/wb_stage.sv | 203 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback path.
//  wb_sel_e : writeback data source selector
//  F3_*     : load funct3 encodings
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // Encodings 3, 6 and 7 are not loads in RV32I.
    function automatic logic f3_is_illegal(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load data alignment and extension.
//  funct3_i   : load width/sign
//  addr_lo_i  : byte address [1:0]
//  rdata_i    : raw aligned word from data memory
//  data_o     : aligned, extended load value
//  misaligned_o : halfword/word access not naturally aligned
//  illegal_o  : funct3 is not a load encoding
module load_aligner
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte and halfword lane selection
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension by load type
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

    always_comb begin
        illegal_o    = f3_is_illegal(funct3_i);
        misaligned_o = 1'b0;
        if ((funct3_i == F3_LH) || (funct3_i == F3_LHU)) begin
            misaligned_o = addr_lo_i[0];
        end else if (funct3_i == F3_LW) begin
            misaligned_o = (addr_lo_i != 2'd0);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from execute, waits for load
// responses, and drives the register-file write port plus a forwarding copy.
//  clk, rst        : clock, synchronous active-high reset
//  ex_*            : instruction from execute (valid/ready handshake)
//  dmem_rsp_valid/dmem_rdata : load response
//  rf_en/rd/wdata  : registered register-file write port
//  fwd_*           : combinational copies of the write port
//  retire          : pulse per completed instruction
//  load_fault      : pulse on misaligned/illegal/timed-out load
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_rf_we,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [1:0]       ex_wb_sel,
    input  logic [2:0]       ex_funct3,
    input  logic [1:0]       ex_addr_lo,
    input  logic [XLEN-1:0]  ex_alu_res,
    input  logic [XLEN-1:0]  ex_pc4,
    input  logic [XLEN-1:0]  ex_csr_rdata,
    input  logic             dmem_rsp_valid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_en,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  wdata,
    output logic             fwd_valid,
    output logic [REG_W-1:0] fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             retire,
    output logic             load_fault
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_addr_q, ld_addr_d;
    logic             ld_we_q, ld_we_d;

    logic             rf_en_q, rf_en_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             retire_q, retire_d;
    logic             fault_q, fault_d;

    logic             accept;
    logic             is_mem;
    logic             timeout;
    logic [2:0]       al_f3;
    logic [1:0]       al_addr;
    logic [XLEN-1:0]  al_data;
    logic             al_misaligned;
    logic             al_illegal;
    logic [XLEN-1:0]  nonmem_data;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = (ex_wb_sel == 2'(WB_MEM));
    assign timeout  = (state_q == WAIT_MEM) && (cnt_q == CNT_LAST);

    // One aligner serves both the accept-time check and the response path.
    assign al_f3   = (state_q == IDLE) ? ex_funct3  : ld_f3_q;
    assign al_addr = (state_q == IDLE) ? ex_addr_lo : ld_addr_q;

    load_aligner u_aligner (
        .funct3_i     (al_f3),
        .addr_lo_i    (al_addr),
        .rdata_i      (dmem_rdata),
        .data_o       (al_data),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    always_comb begin
        case (ex_wb_sel)
            2'(WB_PC4): nonmem_data = ex_pc4;
            2'(WB_CSR): nonmem_data = ex_csr_rdata;
            default:    nonmem_data = ex_alu_res;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_addr_q <= '0;
            ld_we_q   <= 1'b0;
            rf_en_q   <= 1'b0;
            rd_q      <= '0;
            wdata_q   <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_addr_q <= ld_addr_d;
            ld_we_q   <= ld_we_d;
            rf_en_q   <= rf_en_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            retire_q  <= retire_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mem && !al_misaligned && !al_illegal) begin
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (dmem_rsp_valid || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_addr_d = ld_addr_q;
        ld_we_d   = ld_we_q;
        rf_en_d   = 1'b0;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        retire_d  = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        rf_en_d  = ex_rf_we && (ex_rd != '0);
                        rd_d     = ex_rd;
                        wdata_d  = nonmem_data;
                        retire_d = 1'b1;
                    end else if (al_misaligned || al_illegal) begin
                        fault_d  = 1'b1;
                        retire_d = 1'b1;
                    end else begin
                        ld_rd_d   = ex_rd;
                        ld_f3_d   = ex_funct3;
                        ld_addr_d = ex_addr_lo;
                        ld_we_d   = ex_rf_we;
                        cnt_d     = '0;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response on the timeout edge still completes the load.
                if (dmem_rsp_valid) begin
                    rf_en_d  = ld_we_q && (ld_rd_q != '0);
                    rd_d     = ld_rd_q;
                    wdata_d  = al_data;
                    retire_d = 1'b1;
                end else if (timeout) begin
                    fault_d  = 1'b1;
                    retire_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rf_en      = rf_en_q;
    assign rd         = rd_q;
    assign wdata      = wdata_q;
    assign retire     = retire_q;
    assign load_fault = fault_q;

    // Forwarding mirrors the write port, covering the old-value read in the write cycle.
    assign fwd_valid = rf_en_q;
    assign fwd_rd    = rd_q;
    assign fwd_data  = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_rf_we;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_pc4;
    logic [31:0] ex_csr_rdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        rf_en;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        retire;
    logic        load_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rf_we       (ex_rf_we),
        .ex_rd          (ex_rd),
        .ex_wb_sel      (ex_wb_sel),
        .ex_funct3      (ex_funct3),
        .ex_addr_lo     (ex_addr_lo),
        .ex_alu_res     (ex_alu_res),
        .ex_pc4         (ex_pc4),
        .ex_csr_rdata   (ex_csr_rdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .rf_en          (rf_en),
        .rd             (rd),
        .wdata          (wdata),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .retire         (retire),
        .load_fault     (load_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] r, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] al, input logic [31:0] v);
        ex_valid     = 1'b1;
        ex_rf_we     = we;
        ex_rd        = r;
        ex_wb_sel    = sel;
        ex_funct3    = f3;
        ex_addr_lo   = al;
        ex_alu_res   = v;
        ex_pc4       = v ^ 32'h0000_0100;
        ex_csr_rdata = v ^ 32'h0000_C000;
    endtask

    // Issue a load, respond after (gap) idle cycles in WAIT_MEM, check the write.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] al,
                           input logic [31:0] raw, input int gap, input logic [31:0] exp);
        drive(1'b1, 5'd9, 2'd1, f3, al, 32'h0);
        step();
        ex_valid = 1'b0;
        check({tag, "_ready_wait"}, 32'(ex_ready), 32'd0);
        for (int i = 0; i < gap; i++) step();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = raw;
        step();
        dmem_rsp_valid = 1'b0;
        check({tag, "_wdata"}, wdata, exp);
        check({tag, "_wr"}, {26'd0, rf_en, retire, rd}, {26'd0, 1'b1, 1'b1, 5'd9});
        check({tag, "_ready_after"}, 32'(ex_ready), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        ex_valid = 1'b0; ex_rf_we = 1'b0; ex_rd = '0; ex_wb_sel = '0; ex_funct3 = '0;
        ex_addr_lo = '0; ex_alu_res = '0; ex_pc4 = '0; ex_csr_rdata = '0;
        dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        step(); step();
        rst = 1'b0;
        check("rst_outs", {26'd0, rf_en, retire, load_fault, fwd_valid, ex_ready, 1'b0},
              {26'd0, 6'b000010});
        check("rst_rd_wdata", {rd, wdata[26:0]}, 32'd0);

        // Back-to-back non-memory ops
        drive(1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234);
        step();
        check("alu_wdata", wdata, 32'h1234);
        check("alu_ctl", {25'd0, rf_en, retire, rd}, {25'd0, 1'b1, 1'b1, 5'd5});
        check("alu_fwd", {fwd_valid, fwd_rd, fwd_data[25:0]}, {1'b1, 5'd5, 26'h1234});
        drive(1'b1, 5'd6, 2'd2, 3'd0, 2'd0, 32'h0000_0040);
        step();
        check("pc4_wdata", wdata, 32'h0000_0140);
        drive(1'b1, 5'd7, 2'd3, 3'd0, 2'd0, 32'h0000_0ACE);
        step();
        check("csr_wdata", wdata, 32'h0000_CACE);
        check("csr_rd", 32'(rd), 32'd7);
        drive(1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hFFFF);
        step();
        check("x0_ctl", {29'd0, rf_en, fwd_valid, retire}, 32'b001);
        drive(1'b0, 5'd8, 2'd0, 3'd0, 2'd0, 32'h55);
        step();
        check("nowe_ctl", {29'd0, rf_en, retire, 1'b0}, 32'b010);
        ex_valid = 1'b0;
        step();
        check("idle_pulses", {29'd0, rf_en, retire, load_fault}, 32'd0);
        check("idle_hold", wdata, 32'h55);

        // Loads with alignment/extension
        do_load("lb3",  3'd0, 2'd3, 32'h80FF_FFFF, 1, 32'hFFFF_FF80);
        do_load("lbu3", 3'd4, 2'd3, 32'h80FF_FFFF, 1, 32'h0000_0080);
        do_load("lb1",  3'd0, 2'd1, 32'h0000_7F00, 0, 32'h0000_007F);
        do_load("lh2",  3'd1, 2'd2, 32'h8001_1234, 0, 32'hFFFF_8001);
        do_load("lhu0", 3'd5, 2'd0, 32'h8001_F234, 2, 32'h0000_F234);
        do_load("lw0",  3'd2, 2'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);

        // Faulting loads never enter WAIT_MEM
        drive(1'b1, 5'd9, 2'd1, 3'd2, 2'd2, 32'h0);
        step();
        check("lw_mis", {28'd0, load_fault, retire, rf_en, ex_ready}, 32'b1101);
        drive(1'b1, 5'd9, 2'd1, 3'd1, 2'd1, 32'h0);
        step();
        check("lh_mis", {28'd0, load_fault, retire, rf_en, ex_ready}, 32'b1101);
        drive(1'b1, 5'd9, 2'd1, 3'd6, 2'd0, 32'h0);
        step();
        check("f3_illegal", {28'd0, load_fault, retire, rf_en, ex_ready}, 32'b1101);
        ex_valid = 1'b0;
        step();
        check("fault_pulse", {30'd0, load_fault, retire}, 32'd0);

        // Timeout: fault in cycle TO+1 after accept
        drive(1'b1, 5'd10, 2'd1, 3'd2, 2'd0, 32'h0);
        step();
        ex_valid = 1'b0;
        k = 0;
        while (!load_fault && k < 3 * TO) begin
            step();
            k++;
        end
        check("timeout_lat", 32'(k), 32'(TO));
        check("timeout_ctl", {29'd0, rf_en, retire, ex_ready}, 32'b011);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1111_1111;
        step();
        dmem_rsp_valid = 1'b0;
        check("late_rsp", {29'd0, rf_en, retire, load_fault}, 32'd0);

        // Response on the timeout edge wins
        do_load("rsp_wins", 3'd2, 2'd0, 32'h0BAD_F00D, TO - 1, 32'h0BAD_F00D);
        check("rsp_wins_nofault", 32'(load_fault), 32'd0);

        // Reset abandons a pending load
        drive(1'b1, 5'd11, 2'd1, 3'd2, 2'd0, 32'h0);
        step();
        ex_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h2222_2222;
        step();
        dmem_rsp_valid = 1'b0;
        check("rst_abandon", {29'd0, rf_en, retire, ex_ready}, 32'b001);
        drive(1'b1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h0000_ABCD);
        step();
        ex_valid = 1'b0;
        check("post_rst_alu", {rf_en, retire, rd, wdata[24:0]}, {1'b1, 1'b1, 5'd12, 25'h0ABCD});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
